booth_mult_seq: RTL and testbench



---
 rtl/booth_pkg.sv | 41 ++++
 rtl/booth_step.sv | 44 ++++
 rtl/booth_mult_seq.sv | 135 +++++++++++++
 tb/tb_booth_mult_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared types and constants for the sequential radix-2 Booth multiplier.
//   - state_e     : controller states (IDLE, RUN)
//   - booth_op_e  : recoded Booth operation for one step (NOP, ADD, SUB)
//   - CODE_ADD/SUB: {Q0, q_-1} bit pairs that select an add or a subtract
//   - ext_width() : operand width after sign/zero extension
package booth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Operands carry one extra bit so the unsigned mode can reuse the signed
  // Booth datapath: a zero-extended operand is never negative.
  localparam int EXT_BITS = 1;

  localparam logic [1:0] CODE_ADD = 2'b01;
  localparam logic [1:0] CODE_SUB = 2'b10;

  function automatic int ext_width(input int w);
    return w + EXT_BITS;
  endfunction

  function automatic booth_op_e booth_recode(input logic q0, input logic qm1);
    booth_op_e op;
    case ({q0, qm1})
      CODE_ADD: op = OP_ADD;
      CODE_SUB: op = OP_SUB;
      default:  op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step
//   One combinational radix-2 Booth iteration: recode {Q0, q_-1}, add or
//   subtract the multiplicand into the upper half, then arithmetic-shift the
//   whole {A_hi, Q, q_-1} register right by one.
// Ports:
//   a_hi_i  [EW-1:0]  upper accumulator half
//   q_i     [EW-1:0]  multiplier / lower accumulator half
//   qm1_i             q_-1 bit
//   m_i     [EW-1:0]  extended multiplicand
//   a_hi_o, q_o, qm1_o  shifted result of this step
module booth_step
  import booth_pkg::*;
#(
  parameter int EW = 9
) (
  input  logic [EW-1:0] a_hi_i,
  input  logic [EW-1:0] q_i,
  input  logic          qm1_i,
  input  logic [EW-1:0] m_i,
  output logic [EW-1:0] a_hi_o,
  output logic [EW-1:0] q_o,
  output logic          qm1_o
);

  booth_op_e     op;
  logic [EW-1:0] sum;

  always_comb begin
    op  = booth_recode(q_i[0], qm1_i);
    sum = a_hi_i;
    case (op)
      OP_ADD:  sum = a_hi_i + m_i;
      OP_SUB:  sum = a_hi_i - m_i;
      default: sum = a_hi_i;
    endcase
  end

  // The carry/borrow out of the EW-bit add is dropped; sign of the
  // truncated sum is replicated into the vacated MSB.
  assign a_hi_o = {sum[EW-1], sum[EW-1:1]};
  assign q_o    = {sum[0], q_i[EW-1:1]};
  assign qm1_o  = q_i[0];

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential radix-2 Booth multiplier with per-operation signed/unsigned
//   mode and a start/busy/done handshake. One multiplication in flight.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active low
//   start        request, accepted only while busy=0
//   signed_mode  1: two's complement operands, 0: unsigned (sampled with start)
//   a [WIDTH-1:0]  multiplicand (sampled with start)
//   b [WIDTH-1:0]  multiplier   (sampled with start)
//   busy         operation in progress
//   done         one-cycle pulse, y updated this cycle
//   y [2*WIDTH-1:0] product, held until the next done
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; y holds the last product
// RUN   | one Booth step per clock, WIDTH+1 steps, then back to IDLE
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y
);

  localparam int EW = ext_width(WIDTH);
  // Counter value during the last of the WIDTH+1 steps.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [EW-1:0]      a_hi_q, a_hi_d;
  logic [EW-1:0]      q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [EW-1:0]      m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               done_q, done_d;

  logic [EW-1:0]      a_ext, b_ext;
  logic [EW-1:0]      a_hi_nx, q_nx;
  logic               qm1_nx;

  assign a_ext = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
  assign b_ext = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};

  booth_step #(
    .EW (EW)
  ) u_step (
    .a_hi_i (a_hi_q),
    .q_i    (q_q),
    .qm1_i  (qm1_q),
    .m_i    (m_q),
    .a_hi_o (a_hi_nx),
    .q_o    (q_nx),
    .qm1_o  (qm1_nx)
  );

  always_comb begin
    state_d = state_q;
    a_hi_d  = a_hi_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_hi_d  = '0;
          q_d     = b_ext;
          qm1_d   = 1'b0;
          m_d     = a_ext;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_hi_d = a_hi_nx;
        q_d    = q_nx;
        qm1_d  = qm1_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // {A_hi, Q} is 2*WIDTH+2 bits; the product always fits in the
          // low 2*WIDTH, i.e. the low WIDTH-1 bits of A_hi plus all of Q.
          y_d     = {a_hi_nx[WIDTH-2:0], q_nx};
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_hi_q  <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_hi_q  <= a_hi_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] y;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .y           (y)
  );

  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_pass   = 0;
  int             done_cnt = 0;
  int             cyc      = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    logic           done_prev;
    logic [2*W-1:0] e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("done_single_cycle", done_prev, 0);
        check("busy_low_at_done", busy, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: y=0x%0h with empty scoreboard", y);
        end else begin
          e = exp_q.pop_front();
          check("product", y, e);
        end
      end
      done_prev = done;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("wait_idle_timeout", n, 0);
  endtask

  // Issue one operation, check latency and that y holds the previous product.
  task automatic do_op(input logic sm, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [2*W-1:0] exp);
    int n = 0;
    wait_idle();
    signed_mode = sm;
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~av;
    b = ~bv;
    signed_mode = ~sm;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 4) check("y_held_mid_op", y, last_exp);
    end
    check("latency", n, W + 1);
    last_exp = exp;
  endtask

  initial begin : stim
    int t1, t2, n, dc;
    logic [W-1:0] ra, rb;
    logic         rsm;
    logic signed [2*W-1:0] sp;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_y", y, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b1, 8'd7,   8'hFD, 16'hFFEB);
    do_op(1'b0, 8'hFF,  8'hFF, 16'hFE01);
    do_op(1'b1, 8'hFF,  8'hFF, 16'h0001);
    do_op(1'b1, 8'h80,  8'h80, 16'h4000);
    do_op(1'b1, 8'h80,  8'h7F, 16'hC080);
    do_op(1'b0, 8'h00,  8'hAB, 16'h0000);
    do_op(1'b0, 8'h80,  8'h7F, 16'h3F80);
    do_op(1'b1, 8'h7F,  8'h7F, 16'h3F01);
    do_op(1'b0, 8'hFF,  8'h01, 16'h00FF);
    do_op(1'b1, 8'hFF,  8'h01, 16'hFFFF);

    // Back-to-back with start held, plus ignored mid-operation pulses.
    wait_idle();
    signed_mode = 1'b1;
    a = 8'd3;
    b = 8'd5;
    start = 1'b1;
    exp_q.push_back(16'h000F);
    @(posedge clk);
    #1;
    a = 8'd12;
    b = 8'hFF;
    exp_q.push_back(16'hFFF4);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    t1 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy_after_accept", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    signed_mode = 1'b0;
    a = 8'h55;
    b = 8'h66;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    t2 = cyc;
    check("b2b_interval", t2 - t1, W + 2);
    last_exp = 16'hFFF4;

    // Reset during the fourth step abandons the operation.
    wait_idle();
    signed_mode = 1'b1;
    a = 8'd50;
    b = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midop_reset_busy", busy, 0);
    check("midop_reset_done", done, 0);
    check("midop_reset_y", y, 0);
    last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, dc);
    do_op(1'b0, 8'h10, 8'h10, 16'h0100);

    // Small random sweep against the arithmetic product.
    for (int i = 0; i < 60; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rsm = 1'($urandom);
      if (rsm) sp = $signed(ra) * $signed(rb);
      else     sp = $signed({8'b0, ra} * {8'b0, rb});
      do_op(rsm, ra, rb, sp);
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
